turn_sequencer: RTL and testbench

TURN_SEQUENCER -- requirements
Module: turn_sequencer

---
 rtl/turn_sequencer.sv | 111 +++++++++++
 tb/tb_turn_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Turn sequencer for a multi-player card/board game: rotates the active player, issues the
// move strobe on a matching card, forfeits idle turns and detects the winner.
module turn_sequencer #(
  parameter int unsigned WIN_POS = 24,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] num_players,
  input  logic       card_valid,
  input  logic       match,
  input  logic [4:0] cur_cnt,
  output logic [1:0] T,
  output logic       D,
  output logic       card_ready,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitCard = 3'd1,
    StEval     = 3'd2,
    StMove     = 3'd3,
    StCheck    = 3'd4,
    StNext     = 3'd5,
    StDone     = 3'd6
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_t;
  logic [1:0]  r_winner;
  logic [1:0]  r_np;
  logic [15:0] r_cnt;
  logic        w_timeout;
  logic        w_win;

  assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));
  assign w_win     = (32'(cur_cnt) >= WIN_POS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:     if (start) w_state_nxt = StWaitCard;
      // A card arriving on the last allowed cycle still counts.
      StWaitCard: begin
        if (card_valid) begin
          w_state_nxt = StEval;
        end else if (w_timeout) begin
          w_state_nxt = StNext;
        end
      end
      StEval:     w_state_nxt = match ? StMove : StNext;
      StMove:     w_state_nxt = StCheck;
      StCheck:    w_state_nxt = w_win ? StDone : StWaitCard;
      StNext:     w_state_nxt = StWaitCard;
      StDone:     if (start) w_state_nxt = StWaitCard;
      default:    w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    state      = r_state;
    D          = (r_state == StMove);
    card_ready = (r_state == StWaitCard);
    game_over  = (r_state == StDone);
    T          = r_t;
    winner     = r_winner;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t      <= 2'd0;
      r_winner <= 2'd0;
      r_np     <= 2'd1;
      r_cnt    <= 16'd0;
    end else begin
      // Counter only runs while parked in WAIT_CARD; zero on every fresh entry.
      r_cnt <= (r_state == StWaitCard && w_state_nxt == StWaitCard) ? r_cnt + 16'd1 : 16'd0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_t  <= 2'd0;
            r_np <= (num_players == 2'd0) ? 2'd1 : num_players;
          end
        end
        StCheck: if (w_win) r_winner <= r_t;
        StNext:  r_t <= (r_t < r_np) ? r_t + 2'd1 : 2'd0;
        StDone: begin
          if (start) begin
            r_t      <= 2'd0;
            r_winner <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: a game-rules model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_turn_sequencer;

  localparam int unsigned WinPos  = 24;
  localparam int unsigned Timeout = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] num_players;
  logic       card_valid;
  logic       match;
  logic [4:0] cur_cnt;
  logic [1:0] T;
  logic       D;
  logic       card_ready;
  logic       game_over;
  logic [1:0] winner;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  turn_sequencer #(
    .WIN_POS(WinPos),
    .TIMEOUT(Timeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_players(num_players),
    .card_valid (card_valid),
    .match      (match),
    .cur_cnt    (cur_cnt),
    .T          (T),
    .D          (D),
    .card_ready (card_ready),
    .game_over  (game_over),
    .winner     (winner),
    .state      (state)
  );

  // Game-rules model: phase codes are the published debug encodings.
  int m_st    = 0;
  int m_t     = 0;
  int m_np    = 1;
  int m_win   = 0;
  int m_wait  = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_t = 0; m_win = 0; m_wait = 0; m_valid = 1'b1;
    end else begin
      case (m_st)
        0: if (start) begin
          m_st = 1; m_t = 0; m_wait = 0;
          m_np = (num_players == 0) ? 2 : int'(num_players) + 1;
        end
        1: begin
          if (card_valid) m_st = 2;
          else if (m_wait + 1 == int'(Timeout)) m_st = 5;
          else m_wait++;
        end
        2: m_st = match ? 3 : 5;
        3: m_st = 4;
        4: begin
          if (int'(cur_cnt) >= int'(WinPos)) begin
            m_st = 6; m_win = m_t;
          end else begin
            m_st = 1; m_wait = 0;
          end
        end
        5: begin
          m_t = (m_t + 1) % m_np; m_st = 1; m_wait = 0;
        end
        6: if (start) begin
          m_st = 1; m_t = 0; m_win = 0; m_wait = 0;
        end
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_tests++;
      if (state !== 3'(m_st) || T !== 2'(m_t) || D !== (m_st == 3) ||
          card_ready !== (m_st == 1) || game_over !== (m_st == 6) || winner !== 2'(m_win)) begin
        n_fail++;
        $display("FAIL model t=%0t: got st=%0d T=%0d D=%b rdy=%b go=%b win=%0d, want st=%0d T=%0d D=%0d rdy=%0d go=%0d win=%0d",
                 $time, state, T, D, card_ready, game_over, winner,
                 m_st, m_t, m_st == 3, m_st == 1, m_st == 6, m_win);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse card_valid for one cycle; afterwards the DUT sits in EVAL.
  task automatic flip(input logic m, input logic [4:0] cnt);
    card_valid = 1'b1; match = m; cur_cnt = cnt;
    tick();
    card_valid = 1'b0;
  endtask

  initial begin
    int exp_t[4];
    exp_t = '{1, 2, 3, 0};
    reset = 1'b1; start = 1'b0; card_valid = 1'b0; match = 1'b0;
    num_players = 2'd3; cur_cnt = 5'd0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_state", int'(state), 0);
    chk("reset_T", int'(T), 0);
    chk("reset_ready", int'(card_ready), 0);
    chk("reset_go", int'(game_over), 0);

    start = 1'b1; tick(); start = 1'b0;
    chk("start_state", int'(state), 1);
    chk("start_T", int'(T), 0);

    for (int i = 0; i < 4; i++) begin
      flip(1'b0, 5'd0);
      chk("miss_eval", int'(state), 2);
      tick();
      chk("miss_D", int'(D), 0);
      tick();
      chk("miss_T", int'(T), exp_t[i]);
    end

    flip(1'b0, 5'd0); tick(); tick();
    chk("to_p1", int'(T), 1);
    flip(1'b1, 5'd5);
    tick();
    chk("hit_D_pulse", int'(D), 1);
    tick();
    chk("hit_D_clear", int'(D), 0);
    chk("hit_check", int'(state), 4);
    tick();
    chk("hit_same_T", int'(T), 1);
    chk("hit_wait", int'(state), 1);

    flip(1'b1, 5'd24); tick(); tick(); tick();
    chk("win_go", int'(game_over), 1);
    chk("win_who", int'(winner), 1);
    card_valid = 1'b1; tick(); card_valid = 1'b0;
    chk("done_ignores_card", int'(state), 6);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_state", int'(state), 1);
    chk("restart_T", int'(T), 0);
    chk("restart_winner", int'(winner), 0);

    match = 1'b0;
    repeat (7) tick();
    chk("to_cycle8", int'(state), 1);
    tick();
    chk("to_next", int'(state), 5);
    tick();
    chk("to_T", int'(T), 1);
    repeat (7) tick();
    card_valid = 1'b1; tick(); card_valid = 1'b0;
    chk("to_card_wins", int'(state), 2);
    tick(); tick();
    chk("to_card_T", int'(T), 2);

    reset = 1'b1; num_players = 2'd0; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("np0_start", int'(state), 1);
    flip(1'b0, 5'd0); tick(); tick();
    chk("np0_T1", int'(T), 1);
    flip(1'b0, 5'd0); tick(); tick();
    chk("np0_wrap", int'(T), 0);

    flip(1'b1, 5'd0); tick();
    chk("rst_in_move_D", int'(D), 1);
    reset = 1'b1; start = 1'b1; tick();
    chk("rst_state", int'(state), 0);
    chk("rst_D", int'(D), 0);
    reset = 1'b0; start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
